// File: rtl/ahb_arbiter.sv
// Multi-master AHB bus arbiter: round-robin grant with burst and HLOCK tracking,
// plus the address-phase and data-phase owner pipeline for the interconnect muxes.
module ahb_arbiter #(
  parameter int NUM_MASTER     = 3,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = (NUM_MASTER > 2) ? $clog2(NUM_MASTER) : 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [NUM_MASTER-1:0] HBUSREQ,
  input  logic [NUM_MASTER-1:0] HLOCK,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HBURST,
  input  logic                  HREADY,
  output logic [NUM_MASTER-1:0] HGRANT,
  output logic [MW-1:0]         HMASTER,
  output logic [MW-1:0]         HMASTER_DP,
  output logic                  HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] BURST_INCR = 3'd1;

  localparam logic [NUM_MASTER-1:0] ONE_HOT0   = {{(NUM_MASTER-1){1'b0}}, 1'b1};
  localparam logic [NUM_MASTER-1:0] DEFAULT_OH = ONE_HOT0 << DEFAULT_MASTER;
  localparam logic [MW-1:0]         DEFAULT_IX = MW'(DEFAULT_MASTER);

  logic [NUM_MASTER-1:0] grant_r;
  logic [MW-1:0]         master_r;
  logic [MW-1:0]         master_dp_r;
  logic                  mastlock_r;
  logic [3:0]            cnt_r;

  logic [MW-1:0]         owner_s;
  logic [3:0]            cnt_next_s;
  logic                  rearb_s;
  logic                  found_s;
  logic [MW-1:0]         sel_s;
  logic [NUM_MASTER-1:0] next_grant_s;

  // Remaining beats after the current one, minus nothing: a fixed burst loads beats-1.
  function automatic logic [3:0] burst_last(input logic [2:0] burst);
    logic [3:0] last;
    case (burst)
      3'd2, 3'd3: last = 4'd3;
      3'd4, 3'd5: last = 4'd7;
      3'd6, 3'd7: last = 4'd15;
      default:    last = 4'd0;
    endcase
    return last;
  endfunction

  function automatic logic [MW-1:0] oh_to_idx(input logic [NUM_MASTER-1:0] oh);
    logic [MW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_MASTER; i++) begin
      if (oh[i]) begin
        idx = idx | MW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign owner_s = oh_to_idx(grant_r);

  // Beat counter next value; an IDLE mid-burst terminates the burst.
  always_comb begin
    cnt_next_s = cnt_r;
    case (HTRANS)
      TR_NONSEQ: cnt_next_s = burst_last(HBURST);
      TR_SEQ: begin
        if (cnt_r != 4'd0) begin
          cnt_next_s = cnt_r - 4'd1;
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      TR_BUSY:   cnt_next_s = cnt_r;
      TR_IDLE:   cnt_next_s = 4'd0;
      default:   cnt_next_s = cnt_r;
    endcase
  end

  // Undefined-length INCR keeps the bus while its owner still requests it.
  assign rearb_s = (cnt_next_s <= 4'd1) && !HLOCK[owner_s] &&
                   !((HBURST == BURST_INCR) && (HTRANS != TR_IDLE) && HBUSREQ[owner_s]);

  // Rotating search starting after the owner; the owner itself is visited last.
  always_comb begin : rr_search
    logic [MW-1:0] cand_v;
    found_s = 1'b0;
    sel_s   = DEFAULT_IX;
    cand_v  = '0;
    for (int i = 1; i <= NUM_MASTER; i++) begin
      cand_v = MW'((int'(owner_s) + i) % NUM_MASTER);
      if (!found_s && HBUSREQ[cand_v]) begin
        found_s = 1'b1;
        sel_s   = cand_v;
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      next_grant_s = ONE_HOT0 << sel_s;
    end else begin
      next_grant_s = DEFAULT_OH;
    end
  end

  // Grant, ownership pipeline and beat counter; everything holds during wait states.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_r     <= DEFAULT_OH;
      master_r    <= DEFAULT_IX;
      master_dp_r <= DEFAULT_IX;
      mastlock_r  <= 1'b0;
      cnt_r       <= 4'd0;
    end else if (HREADY) begin
      if (rearb_s) begin
        grant_r <= next_grant_s;
      end
      master_r    <= owner_s;
      master_dp_r <= master_r;
      mastlock_r  <= HLOCK[owner_s];
      cnt_r       <= cnt_next_s;
    end
  end

  assign HGRANT     = grant_r;
  assign HMASTER    = master_r;
  assign HMASTER_DP = master_dp_r;
  assign HMASTLOCK  = mastlock_r;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: each driven cycle queues its hand-derived
// expected grant/owner state, which is popped and compared after the clock edge.
module tb_ahb_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [2:0] HBUSREQ;
  logic [2:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [2:0] HGRANT;
  logic [1:0] HMASTER;
  logic [1:0] HMASTER_DP;
  logic       HMASTLOCK;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] g;
    logic [1:0] m;
    logic [1:0] d;
    logic       l;
  } exp_t;

  exp_t sb_q[$];

  ahb_arbiter #(.NUM_MASTER(3), .DEFAULT_MASTER(0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HGRANT(HGRANT),
    .HMASTER(HMASTER), .HMASTER_DP(HMASTER_DP), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".grant"},  32'(HGRANT),     32'(e.g));
    check({tag, ".master"}, 32'(HMASTER),    32'(e.m));
    check({tag, ".dp"},     32'(HMASTER_DP), 32'(e.d));
    check({tag, ".lock"},   32'(HMASTLOCK),  32'(e.l));
  endtask

  // Drive one cycle, queue its expected post-edge state, then compare after the edge.
  task automatic step(input string tag, input logic [1:0] tr, input logic [2:0] bu,
                      input logic [2:0] req, input logic [2:0] lk, input logic rdy,
                      input logic [2:0] eg, input logic [1:0] em, input logic [1:0] ed,
                      input logic el);
    exp_t e;
    HTRANS = tr; HBURST = bu; HBUSREQ = req; HLOCK = lk; HREADY = rdy;
    sb_q.push_back('{g: eg, m: em, d: ed, l: el});
    @(posedge HCLK);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_all(tag, e);
    end
  endtask

  localparam logic [1:0] I = 2'd0, B = 2'd1, N = 2'd2, S = 2'd3;
  localparam logic [2:0] SGL = 3'd0, INC = 3'd1, INC4 = 3'd3, INC8 = 3'd5;

  initial begin
    HRESETn = 1'b0; HBUSREQ = 3'b110; HLOCK = 3'b000;
    HTRANS = I; HBURST = SGL; HREADY = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    check_all("reset", '{g: 3'b001, m: 2'd0, d: 2'd0, l: 1'b0});
    HRESETn = 1'b1;

    // Round robin: all request, SINGLE transfers
    step("rr1", N, SGL, 3'b111, 3'b000, 1'b1, 3'b010, 2'd0, 2'd0, 1'b0);
    step("rr2", N, SGL, 3'b111, 3'b000, 1'b1, 3'b100, 2'd1, 2'd0, 1'b0);
    step("rr3", N, SGL, 3'b111, 3'b000, 1'b1, 3'b001, 2'd2, 2'd1, 1'b0);
    step("rr4", N, SGL, 3'b111, 3'b000, 1'b1, 3'b010, 2'd0, 2'd2, 1'b0);

    // Fixed INCR4 by master 1, master 2 waiting
    step("b0", N, INC4, 3'b110, 3'b000, 1'b1, 3'b010, 2'd1, 2'd0, 1'b0);
    step("b1", S, INC4, 3'b110, 3'b000, 1'b1, 3'b010, 2'd1, 2'd1, 1'b0);
    step("b2", S, INC4, 3'b110, 3'b000, 1'b1, 3'b100, 2'd1, 2'd1, 1'b0);
    step("b3", S, INC4, 3'b100, 3'b000, 1'b1, 3'b100, 2'd2, 2'd1, 1'b0);
    step("b4", N, SGL,  3'b100, 3'b000, 1'b1, 3'b100, 2'd2, 2'd2, 1'b0);

    // INCR4 by master 2 with three wait states in beat 1
    step("w0",  N, INC4, 3'b101, 3'b000, 1'b1, 3'b100, 2'd2, 2'd2, 1'b0);
    step("ws1", S, INC4, 3'b101, 3'b000, 1'b0, 3'b100, 2'd2, 2'd2, 1'b0);
    step("ws2", S, INC4, 3'b101, 3'b000, 1'b0, 3'b100, 2'd2, 2'd2, 1'b0);
    step("ws3", S, INC4, 3'b101, 3'b000, 1'b0, 3'b100, 2'd2, 2'd2, 1'b0);
    step("w1",  S, INC4, 3'b101, 3'b000, 1'b1, 3'b100, 2'd2, 2'd2, 1'b0);
    step("w2",  S, INC4, 3'b101, 3'b000, 1'b1, 3'b001, 2'd2, 2'd2, 1'b0);
    step("w3",  S, INC4, 3'b001, 3'b000, 1'b1, 3'b001, 2'd0, 2'd2, 1'b0);

    // Locked transfers by master 2
    step("l0", I, SGL, 3'b100, 3'b000, 1'b1, 3'b100, 2'd0, 2'd0, 1'b0);
    step("l1", N, SGL, 3'b111, 3'b100, 1'b1, 3'b100, 2'd2, 2'd0, 1'b1);
    step("l2", N, SGL, 3'b111, 3'b100, 1'b1, 3'b100, 2'd2, 2'd2, 1'b1);
    step("l3", I, SGL, 3'b011, 3'b000, 1'b1, 3'b001, 2'd2, 2'd2, 1'b0);
    step("l4", I, SGL, 3'b000, 3'b000, 1'b1, 3'b001, 2'd0, 2'd2, 1'b0);

    // Idle falls back to the default master
    step("d0", I, SGL, 3'b010, 3'b000, 1'b1, 3'b010, 2'd0, 2'd0, 1'b0);
    step("d1", N, SGL, 3'b000, 3'b000, 1'b1, 3'b001, 2'd1, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++)
      step("d_idle", I, SGL, 3'b000, 3'b000, 1'b1, 3'b001, 2'd0,
           (k == 0) ? 2'd1 : 2'd0, 1'b0);

    // INCR held while the owner requests, released once it drops
    step("i0", I, SGL, 3'b010, 3'b000, 1'b1, 3'b010, 2'd0, 2'd0, 1'b0);
    step("i1", N, INC, 3'b011, 3'b000, 1'b1, 3'b010, 2'd1, 2'd0, 1'b0);
    step("i2", S, INC, 3'b011, 3'b000, 1'b1, 3'b010, 2'd1, 2'd1, 1'b0);
    step("i3", B, INC, 3'b011, 3'b000, 1'b1, 3'b010, 2'd1, 2'd1, 1'b0);
    step("i4", S, INC, 3'b001, 3'b000, 1'b1, 3'b001, 2'd1, 2'd1, 1'b0);
    step("i5", I, SGL, 3'b000, 3'b000, 1'b1, 3'b001, 2'd0, 2'd1, 1'b0);

    // Locked INCR8 by master 2, then asynchronous reset mid-burst
    step("r0", I, SGL,  3'b100, 3'b000, 1'b1, 3'b100, 2'd0, 2'd0, 1'b0);
    step("r1", N, INC8, 3'b100, 3'b100, 1'b1, 3'b100, 2'd2, 2'd0, 1'b1);
    step("r2", S, INC8, 3'b100, 3'b100, 1'b1, 3'b100, 2'd2, 2'd2, 1'b1);
    #2 HRESETn = 1'b0;
    #1 check_all("rst_mid", '{g: 3'b001, m: 2'd0, d: 2'd0, l: 1'b0});
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    // A cleared counter lets a stray SEQ re-arbitrate immediately
    step("r3", S, INC8, 3'b010, 3'b000, 1'b1, 3'b010, 2'd0, 2'd0, 1'b0);

    // Early-terminated INCR4: IDLE drops the counter and frees the bus
    step("e0", N, INC4, 3'b011, 3'b000, 1'b1, 3'b010, 2'd1, 2'd0, 1'b0);
    step("e1", I, INC4, 3'b011, 3'b000, 1'b1, 3'b001, 2'd1, 2'd1, 1'b0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
